// File: rtl/ks_pkg.sv
// Shared types and helpers for the Kogge-Stone pipelined adder.
package ks_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

  // Number of prefix levels for an N-bit operand (ceil(log2(N))).
  function automatic int ks_levels(input int n);
    int l;
    l = 0;
    for (int i = 0; i < 8; i++) begin
      if ((1 << i) < n) l = i + 1;
    end
    return l;
  endfunction

endpackage

// File: rtl/ks_prefix_level.sv
// One Kogge-Stone prefix level: merges (G,P) pairs DIST bits apart, optionally
// registered with its own valid bit and bubble-collapsing load.
module ks_prefix_level
  import ks_pkg::*;
#(
  parameter int N    = 16,
  parameter int DIST = 1,
  parameter bit REG  = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         vld_in,
  input  pg_t  [N-1:0] gp_in,
  input  logic [N-1:0] hp_in,
  input  logic         cin_in,
  input  logic         ld_next,
  output logic         ld_out,
  output logic         vld_out,
  output pg_t  [N-1:0] gp_out,
  output logic [N-1:0] hp_out,
  output logic         cin_out
);

  pg_t [N-1:0] gp_c;

  always_comb begin
    for (int i = 0; i < DIST; i++) begin
      gp_c[i] = gp_in[i];
    end
    for (int i = DIST; i < N; i++) begin
      gp_c[i].g = gp_in[i].g | (gp_in[i].p & gp_in[i-DIST].g);
      gp_c[i].p = gp_in[i].p & gp_in[i-DIST].p;
    end
  end

  if (REG) begin : g_reg
    logic         vld_p1;
    pg_t  [N-1:0] gp_p1;
    logic [N-1:0] hp_p1;
    logic         cin_p1;
    logic         ld_p1;

    assign ld_p1 = !vld_p1 || ld_next;

    // ---- level register ----
    always_ff @(posedge clk) begin
      if (!rst_n) vld_p1 <= 1'b0;
      else if (ld_p1) vld_p1 <= vld_in;
    end

    always_ff @(posedge clk) begin
      if (ld_p1 && vld_in) begin
        gp_p1  <= gp_c;
        hp_p1  <= hp_in;
        cin_p1 <= cin_in;
      end
    end

    assign ld_out  = ld_p1;
    assign vld_out = vld_p1;
    assign gp_out  = gp_p1;
    assign hp_out  = hp_p1;
    assign cin_out = cin_p1;
  end else begin : g_comb
    logic unused_ctrl;
    assign unused_ctrl = clk ^ rst_n;
    assign ld_out  = ld_next;
    assign vld_out = vld_in;
    assign gp_out  = gp_c;
    assign hp_out  = hp_in;
    assign cin_out = cin_in;
  end

endmodule

// File: rtl/ks_pipe_adder.sv
// Pipelined Kogge-Stone add/subtract with valid/ready flow control:
// operand stage, L prefix levels (optionally registered), result/flag stage.
module ks_pipe_adder
  import ks_pkg::*;
#(
  parameter int N          = 16,
  parameter int REG_LEVELS = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  ks_pkg::op_t  op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int L = ks_levels(N);

  logic [N-1:0] b_eff, hp_d;
  logic         c_eff;
  pg_t  [N-1:0] gp_d;

  always_comb begin
    b_eff = (op == OP_SUB) ? ~b : b;
    c_eff = (op == OP_SUB) ? 1'b1 : cin;
    hp_d  = a ^ b_eff;
    for (int i = 0; i < N; i++) begin
      gp_d[i].g = a[i] & b_eff[i];
      gp_d[i].p = hp_d[i];
    end
    // Folding the carry-in into bit 0 makes every prefix group include it.
    gp_d[0].g = (a[0] & b_eff[0]) | (hp_d[0] & c_eff);
  end

  logic         vld_p0, ld_p0;
  pg_t  [N-1:0] gp_p0;
  logic [N-1:0] hp_p0;
  logic         cin_p0;

  logic [L:0]   vld_l, ld_l, cin_l;
  pg_t  [N-1:0] gp_l [L+1];
  logic [N-1:0] hp_l [L+1];

  assign ld_p0    = !vld_p0 || ld_l[0];
  assign in_ready = rst_n && ld_p0;

  // ---- stage 0: operand capture ----
  always_ff @(posedge clk) begin
    if (!rst_n) vld_p0 <= 1'b0;
    else if (ld_p0) vld_p0 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (ld_p0 && in_valid) begin
      gp_p0  <= gp_d;
      hp_p0  <= hp_d;
      cin_p0 <= c_eff;
    end
  end

  assign vld_l[0] = vld_p0;
  assign gp_l[0]  = gp_p0;
  assign hp_l[0]  = hp_p0;
  assign cin_l[0] = cin_p0;

  // ---- prefix levels ----
  for (genvar k = 0; k < L; k++) begin : g_lvl
    ks_prefix_level #(
      .N    (N),
      .DIST (1 << k),
      .REG  (REG_LEVELS != 0)
    ) u_lvl (
      .clk     (clk),
      .rst_n   (rst_n),
      .vld_in  (vld_l[k]),
      .gp_in   (gp_l[k]),
      .hp_in   (hp_l[k]),
      .cin_in  (cin_l[k]),
      .ld_next (ld_l[k+1]),
      .ld_out  (ld_l[k]),
      .vld_out (vld_l[k+1]),
      .gp_out  (gp_l[k+1]),
      .hp_out  (hp_l[k+1]),
      .cin_out (cin_l[k+1])
    );
  end

  logic [N-1:0] carry, sum_d, p_fin;
  logic         cout_d, ovf_d, zero_d;
  logic         unused_p;

  always_comb begin
    carry[0] = cin_l[L];
    for (int i = 1; i < N; i++) begin
      carry[i] = gp_l[L][i-1].g;
    end
    for (int i = 0; i < N; i++) begin
      p_fin[i] = gp_l[L][i].p;
    end
    sum_d  = hp_l[L] ^ carry;
    cout_d = gp_l[L][N-1].g;
    ovf_d  = cout_d ^ carry[N-1];
    zero_d = (sum_d == '0);
  end

  assign unused_p = ^p_fin;

  logic         vld_p2, ld_p2;
  logic [N-1:0] sum_p2;
  logic         cout_p2, ovf_p2, zero_p2;

  assign ld_p2    = !vld_p2 || out_ready;
  assign ld_l[L]  = ld_p2;

  // ---- result stage: sum and flags ----
  always_ff @(posedge clk) begin
    if (!rst_n) vld_p2 <= 1'b0;
    else if (ld_p2) vld_p2 <= vld_l[L];
  end

  always_ff @(posedge clk) begin
    if (ld_p2 && vld_l[L]) begin
      sum_p2  <= sum_d;
      cout_p2 <= cout_d;
      ovf_p2  <= ovf_d;
      zero_p2 <= zero_d;
    end
  end

  // Payload registers are not reset; outputs read as zero whenever empty.
  assign out_valid = vld_p2;
  assign sum       = vld_p2 ? sum_p2 : '0;
  assign cout      = vld_p2 && cout_p2;
  assign ovf       = vld_p2 && ovf_p2;
  assign zero      = vld_p2 && zero_p2;

endmodule

// File: tb/tb_ks_pipe_adder.sv
// Scoreboard bench: six adder configurations (N = 16/4/64, REG_LEVELS = 1/0)
// driven from one stimulus stream, each checked against an arithmetic model.
module tb_ks_pipe_adder;
  import ks_pkg::*;

  localparam int NI = 6;

  localparam logic [3:0] F_ACC_CLR = 4'b0001;
  localparam logic [3:0] F_CAP     = 4'b0010;
  localparam logic [3:0] F_TPUT    = 4'b0100;
  localparam logic [3:0] F_END     = 4'b1000;

  function automatic int cfg_n(input int i);
    case (i)
      0, 1:    return 16;
      2, 3:    return 4;
      default: return 64;
    endcase
  endfunction

  function automatic int cfg_r(input int i);
    return (i % 2 == 0) ? 1 : 0;
  endfunction

  // Registers between accept and result: also the stall capacity.
  function automatic int depth_of(input int i);
    return (cfg_r(i) != 0) ? $clog2(cfg_n(i)) + 2 : 2;
  endfunction

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    longint      cyc;
    bit          lat;
  } exp_t;

  function automatic exp_t model(input int n, input logic [63:0] av, input logic [63:0] bv,
                                 input logic c, input op_t o);
    exp_t        e;
    logic [63:0] mask, aa, bb;
    logic [64:0] full;
    mask   = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    aa     = av & mask;
    bb     = ((o == OP_SUB) ? ~bv : bv) & mask;
    full   = {1'b0, aa} + {1'b0, bb} + ((o == OP_SUB) ? 65'd1 : {64'd0, c});
    e.sum  = full[63:0] & mask;
    e.cout = full[n];
    e.ovf  = (aa[n-1] == bb[n-1]) && (e.sum[n-1] != aa[n-1]);
    e.zero = (e.sum == 64'd0);
    e.cyc  = 0;
    e.lat  = 1'b0;
    return e;
  endfunction

  logic        clk, rst_n, in_valid, out_ready, cin_s;
  logic [63:0] a_s, b_s;
  op_t         op_s;
  logic [3:0]  mflags;

  logic        in_ready_w [NI];
  logic        out_valid_w[NI];
  logic        cout_w     [NI];
  logic        ovf_w      [NI];
  logic        zero_w     [NI];
  logic [63:0] sum_w      [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int NW = cfg_n(g);
    localparam int RW = cfg_r(g);
    logic [NW-1:0] s;
    logic          ir, ov, co, of, zr;
    ks_pipe_adder #(.N(NW), .REG_LEVELS(RW)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (ir),
      .a         (a_s[NW-1:0]),
      .b         (b_s[NW-1:0]),
      .cin       (cin_s),
      .op        (op_s),
      .out_valid (ov),
      .out_ready (out_ready),
      .sum       (s),
      .cout      (co),
      .ovf       (of),
      .zero      (zr)
    );
    assign in_ready_w[g]  = ir;
    assign out_valid_w[g] = ov;
    assign cout_w[g]      = co;
    assign ovf_w[g]       = of;
    assign zero_w[g]      = zr;
    assign sum_w[g]       = 64'(s);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t q[NI][$];
  int   checks = 0;
  int   errors = 0;
  int   bp_acc0 = 0;
  bit   lat_mode = 1'b0;
  bit   dir_on = 1'b0;
  exp_t dir_e;

  // ---------------- monitor ----------------
  int          acc    [NI];
  bit          post_rst[NI];
  bit          stall  [NI];
  logic [63:0] hold_s [NI];
  logic [2:0]  hold_f [NI];

  task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d (N=%0d REG=%0d) t=%0t: got %0h expected %0h",
               nm, i, cfg_n(i), cfg_r(i), $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        chk("in_ready_during_reset", i, 64'(in_ready_w[i]), 64'd0);
        q[i].delete();
        post_rst[i] = 1'b1;
        stall[i]    = 1'b0;
        acc[i]      = 0;
      end else begin
        if (post_rst[i]) begin
          chk("reset_out_valid", i, 64'(out_valid_w[i]), 64'd0);
          chk("reset_sum", i, sum_w[i], 64'd0);
          chk("reset_flags", i, 64'({cout_w[i], ovf_w[i], zero_w[i]}), 64'd0);
          chk("in_ready_after_release", i, 64'(in_ready_w[i]), 64'd1);
          post_rst[i] = 1'b0;
        end
        if (stall[i]) begin
          chk("stall_out_valid", i, 64'(out_valid_w[i]), 64'd1);
          chk("stall_sum_held", i, sum_w[i], hold_s[i]);
          chk("stall_flags_held", i, 64'({cout_w[i], ovf_w[i], zero_w[i]}), 64'(hold_f[i]));
        end
        if (out_valid_w[i] && out_ready) begin
          chk("result_expected", i, 64'(q[i].size() > 0), 64'd1);
          if (q[i].size() > 0) begin
            exp_t e;
            e = q[i].pop_front();
            chk("sum", i, sum_w[i], e.sum);
            chk("cout_ovf_zero", i, 64'({cout_w[i], ovf_w[i], zero_w[i]}),
                64'({e.cout, e.ovf, e.zero}));
            if (e.lat) chk("latency", i, 64'(cyc - e.cyc), 64'(depth_of(i)));
          end
        end
        stall[i]  = out_valid_w[i] && !out_ready;
        hold_s[i] = sum_w[i];
        hold_f[i] = {cout_w[i], ovf_w[i], zero_w[i]};
        if (mflags[2]) chk("throughput_in_ready", i, 64'(in_ready_w[i]), 64'd1);
        if (mflags[1]) begin
          chk("stall_capacity", i, 64'(acc[i]), 64'(depth_of(i)));
          chk("stall_in_ready", i, 64'(in_ready_w[i]), 64'd0);
        end
        if (mflags[3]) begin
          chk("drained", i, 64'(q[i].size()), 64'd0);
          if (i == 0) chk("backpressure_beats", i, 64'(bp_acc0), 64'd8);
        end
        if (mflags[0]) acc[i] = 0;
        else if (in_valid && in_ready_w[i]) acc[i]++;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic cycle_beat(input bit v, input logic [63:0] av, input logic [63:0] bv,
                            input logic c, input op_t o, input bit ordy,
                            input logic [3:0] fl, output bit acc0);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid  = v;
    a_s       = av;
    b_s       = bv;
    cin_s     = c;
    op_s      = o;
    out_ready = ordy;
    mflags    = fl;
    @(negedge clk);
    acc0 = v && rst_n && in_ready_w[0];
    for (int i = 0; i < NI; i++) begin
      if (v && rst_n && in_ready_w[i]) begin
        e = model(cfg_n(i), av, bv, c, o);
        if (dir_on && cfg_n(i) == 16) begin
          e.sum  = dir_e.sum;
          e.cout = dir_e.cout;
          e.ovf  = dir_e.ovf;
          e.zero = dir_e.zero;
        end
        e.cyc = cyc;
        e.lat = lat_mode;
        q[i].push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    bit dummy;
    for (int k = 0; k < n; k++) cycle_beat(1'b0, 64'd0, 64'd0, 1'b0, OP_ADD, 1'b1, 4'd0, dummy);
  endtask

  task automatic directed(input logic [15:0] av, input logic [15:0] bv, input logic c, input op_t o,
                          input logic [15:0] es, input logic ec, input logic eo);
    bit dummy;
    dir_on     = 1'b1;
    dir_e.sum  = 64'(es);
    dir_e.cout = ec;
    dir_e.ovf  = eo;
    dir_e.zero = (es == 16'd0);
    cycle_beat(1'b1, 64'(av), 64'(bv), c, o, 1'b1, 4'd0, dummy);
    dir_on = 1'b0;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          acc0;
    logic [63:0] bpa[8], bpb[8];
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a_s = '0; b_s = '0; cin_s = 1'b0; op_s = OP_ADD; mflags = '0;
    idle(3);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(2);

    // Directed vectors; expected values written out for the 16-bit instances.
    directed(16'hFFFF, 16'h0001, 1'b0, OP_ADD, 16'h0000, 1'b1, 1'b0);
    directed(16'h7FFF, 16'h0001, 1'b0, OP_ADD, 16'h8000, 1'b0, 1'b1);
    directed(16'h0005, 16'h0007, 1'b0, OP_SUB, 16'hFFFE, 1'b0, 1'b0);
    directed(16'h8000, 16'h0001, 1'b0, OP_SUB, 16'h7FFF, 1'b1, 1'b1);
    directed(16'h0005, 16'h0005, 1'b0, OP_SUB, 16'h0000, 1'b1, 1'b0);
    directed(16'h1234, 16'h0FFF, 1'b1, OP_ADD, 16'h2234, 1'b0, 1'b0);
    directed(16'h0003, 16'h0001, 1'b1, OP_SUB, 16'h0002, 1'b1, 1'b0);
    idle(10);

    // 100-beat back-to-back random stream: latency and one beat per cycle.
    lat_mode = 1'b1;
    for (int k = 0; k < 100; k++) begin
      cycle_beat(1'b1, rnd64(), rnd64(), 1'($urandom()), op_t'($urandom_range(0, 1)),
                 1'b1, F_TPUT, acc0);
    end
    lat_mode = 1'b0;
    idle(12);

    // Backpressure: 8 beats offered while the output stalls for 10 cycles.
    for (int k = 0; k < 8; k++) begin
      bpa[k] = rnd64();
      bpb[k] = rnd64();
    end
    cycle_beat(1'b0, 64'd0, 64'd0, 1'b0, OP_ADD, 1'b1, F_ACC_CLR, acc0);
    bp_acc0 = 0;
    for (int c = 0; c < 60 && bp_acc0 < 8; c++) begin
      cycle_beat(1'b1, bpa[bp_acc0], bpb[bp_acc0], 1'b0, OP_ADD, (c >= 10),
                 (c == 9) ? F_CAP : 4'd0, acc0);
      if (acc0) bp_acc0++;
    end
    idle(15);

    // Reset with three beats in flight.
    for (int k = 0; k < 3; k++) begin
      cycle_beat(1'b1, rnd64(), rnd64(), 1'b0, OP_ADD, 1'b1, 4'd0, acc0);
    end
    @(posedge clk); #1 rst_n = 1'b0; in_valid = 1'b0; mflags = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    idle(15);

    // Random valid/ready mix.
    for (int k = 0; k < 300; k++) begin
      cycle_beat(($urandom_range(0, 3) != 0), rnd64(), rnd64(), 1'($urandom()),
                 op_t'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7), 4'd0, acc0);
    end
    idle(30);
    cycle_beat(1'b0, 64'd0, 64'd0, 1'b0, OP_ADD, 1'b1, F_END, acc0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ks_pipe_adder.md
KS_PIPE_ADDER -- requirements
Module: ks_pipe_adder

Interface
REQ-001 SHALL have parameter N, default 16: operand width; legal values 4, 8, 16, 32, 64.
REQ-002 SHALL have parameter REG_LEVELS, default 1: 1 = register after every prefix level; 0 = prefix network fully combinational.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, operand beat present.
REQ-006 SHALL have port in_ready, output, 1, beat accepted when in_valid and in_ready are both high at a clk edge.
REQ-007 SHALL have port a, input, N, operand A.
REQ-008 SHALL have port b, input, N, operand B.
REQ-009 SHALL have port cin, input, 1, carry in; ignored when op is OP_SUB.
REQ-010 SHALL have port op, input, ks_pkg::op_t, OP_ADD or OP_SUB.
REQ-011 SHALL have port out_valid, output, 1, result present.
REQ-012 SHALL have port out_ready, input, 1, result consumed when out_valid and out_ready are both high.
REQ-013 SHALL have port sum, output, N, result.
REQ-014 SHALL have port cout, output, 1, carry out; for OP_SUB, 1 means no borrow.
REQ-015 SHALL have port ovf, output, 1, two's-complement signed overflow.
REQ-016 SHALL have port zero, output, 1, high when sum == 0.

Function
REQ-017 SHALL compute, for OP_ADD, {cout,sum} = a + b + cin, and for OP_SUB, {cout,sum} = a + ~b + 1; arithmetic modulo 2^N.
REQ-018 SHALL compute ovf = (opA[N-1] == opB'[N-1]) && (sum[N-1] != opA[N-1]), where opB' is b after OP_SUB inversion.
REQ-019 SHALL form carries with a Kogge-Stone prefix network of L = log2(N) levels; level k combines (G,P) pairs at distance 2^k; bit-0 group generate merges cin.
REQ-020 SHALL register stage 0 (operand capture with per-bit P = a^b', G = a&b') and a final sum/flag stage.
REQ-021 SHALL have latency, from accept to out_valid with no stall, of exactly 2 + L cycles when REG_LEVELS = 1, and exactly 2 when REG_LEVELS = 0.
REQ-022 SHALL sustain throughput of one beat per cycle while out_ready is held high.
REQ-023 SHALL give each pipeline stage a valid bit; a stage SHALL load when it is empty or when its successor loads in the same cycle (bubble collapse).
REQ-024 SHALL drive in_ready combinationally as the stage-0 load condition; in_ready is high whenever any downstream stage holds a bubble.
REQ-025 SHALL hold sum, cout, ovf, zero and out_valid stable while out_valid = 1 and out_ready = 0.
REQ-026 SHALL never drop, duplicate or reorder beats.
REQ-027 SHALL accept a new beat in the same cycle the final result is consumed when the pipeline is full.
REQ-028 SHALL NOT let in_valid-low cycles alter stored data; payload registers of invalid stages are don't-care.

Reset
REQ-029 SHALL, when rst_n is sampled low, clear all stage valid bits, and SHALL drive out_valid = 0, sum = 0, cout = 0, ovf = 0, zero = 0 on the following cycle.
REQ-030 SHALL discard all in-flight beats when reset is asserted mid-operation; no result for them appears after reset is released.
REQ-031 SHALL drive in_ready = 0 while rst_n = 0, and in_ready = 1 in the first cycle after release.

Structure
REQ-032 SHALL take from package ks_pkg: op_t enum (OP_ADD, OP_SUB), a function returning L = log2(N), and the pg_t struct {g, p}.
REQ-033 SHALL contain one sub-module, ks_prefix_level: one prefix level parameterised by N, distance and REG, with per-level valid/load handling; it is instantiated L times in a generate loop.

Verification
REQ-034 SHALL cover, with N = 16 and op OP_ADD: a = 0xFFFF, b = 0x0001, cin = 0 -> sum 0x0000, cout 1, zero 1, ovf 0.
REQ-035 SHALL cover, with N = 16 and OP_ADD: a = 0x7FFF, b = 0x0001, cin = 0 -> sum 0x8000, cout 0, ovf 1.
REQ-036 SHALL cover, with N = 16 and OP_SUB: a = 0x0005, b = 0x0007 -> sum 0xFFFE, cout 0, ovf 0; and a = 0x8000, b = 0x0001 -> sum 0x7FFF, cout 1, ovf 1.
REQ-037 SHALL cover backpressure: 8 back-to-back beats with out_ready low for 10 cycles -> in_ready falls after L + 2 accepts, then all 8 results appear in order, unchanged while stalled.
REQ-038 SHALL cover reset mid-stream: 3 beats in flight, rst_n low for 1 cycle -> out_valid 0 the next cycle and no stale result afterward.
REQ-039 SHALL cover latency and throughput for REG_LEVELS 0 and 1 at N = 4, 16 and 64: measured latency matches REQ-021, and a 100-beat random stream matches the reference model at one beat per cycle.
